// File: rtl/mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_pkg
// Description : Shared types and constants for the word-RAM initiator port.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Lane geometry of a 32-bit little-endian word
    localparam int unsigned c_byte_bits = 8;
    localparam int unsigned c_half_bits = 16;
    localparam int unsigned c_word_bits = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte/halfword lane extraction with sign/zero
//               extension, and store-data merge into a RAM word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_port_pkg::*;
(
    input  logic [1:0]             addr_lo,
    input  logic [1:0]             size,
    input  logic                   is_signed,
    input  logic [c_word_bits-1:0] ram_word,
    input  logic [c_word_bits-1:0] store_data,
    output logic [c_word_bits-1:0] load_data,
    output logic [c_word_bits-1:0] merged_word
);

    logic [c_byte_bits-1:0] w_byte;
    logic [c_half_bits-1:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = ram_word[7:0];
            2'd1:    w_byte = ram_word[15:8];
            2'd2:    w_byte = ram_word[23:16];
            default: w_byte = ram_word[31:24];
        endcase
        w_half = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];

        load_data   = ram_word;
        merged_word = ram_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{is_signed & w_byte[7]}}, w_byte};
                case (addr_lo)
                    2'd0:    merged_word[7:0]   = store_data[7:0];
                    2'd1:    merged_word[15:8]  = store_data[7:0];
                    2'd2:    merged_word[23:16] = store_data[7:0];
                    default: merged_word[31:24] = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = {{16{is_signed & w_half[15]}}, w_half};
                if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
                else            merged_word[15:0]  = store_data[15:0];
            end
            default: begin
                load_data   = ram_word;
                merged_word = store_data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_master
// Description : Byte-addressed load/store initiator for a single-port word
//               RAM, with read-modify-write for sub-word stores.
//               Optional: MEM_PORT_ALIGN_CHECK_EN reports misaligned / illegal
//               size requests through resp_err instead of force-aligning.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_master
    import mem_port_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_err,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_wdata,
    input  logic [WIDTH-1:0]      ram_rdata
);

    state_t           r_state;
    logic             r_write;
    logic             r_signed;
    logic [1:0]       r_size;
    logic [1:0]       r_addr_lo;
    logic [WIDTH-1:0] r_wdata;
    logic             r_ram_write;

    logic             w_accept;
    logic             w_err;
    logic [1:0]       w_size_eff;
    logic [1:0]       w_addr_lo_eff;
    logic [WIDTH-1:0] w_load_data;
    logic [WIDTH-1:0] w_merged;
    logic             w_addr_hi_unused;

    // Address bits above the RAM index are intentionally dropped (wrap-around)
    assign w_addr_hi_unused = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign ram_write = r_ram_write && !reset;

`ifdef MEM_PORT_ALIGN_CHECK_EN
    always_comb begin
        w_size_eff    = req_size;
        w_addr_lo_eff = req_addr[1:0];
        case (req_size)
            SZ_BYTE: w_err = 1'b0;
            SZ_HALF: w_err = req_addr[0];
            SZ_WORD: w_err = |req_addr[1:0];
            default: w_err = 1'b1;
        endcase
    end
`else
    // No error reporting: force alignment and fold the illegal size into word
    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_BYTE: begin
                w_size_eff    = SZ_BYTE;
                w_addr_lo_eff = req_addr[1:0];
            end
            SZ_HALF: begin
                w_size_eff    = SZ_HALF;
                w_addr_lo_eff = {req_addr[1], 1'b0};
            end
            default: begin
                w_size_eff    = SZ_WORD;
                w_addr_lo_eff = 2'b00;
            end
        endcase
    end
`endif

    mem_lane_align u_lane_align (
        .addr_lo     (r_addr_lo),
        .size        (r_size),
        .is_signed   (r_signed),
        .ram_word    (ram_rdata),
        .store_data  (r_wdata),
        .load_data   (w_load_data),
        .merged_word (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= SZ_BYTE;
            r_addr_lo   <= 2'b00;
            r_wdata     <= '0;
            r_ram_write <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            resp_valid  <= 1'b0;
            r_ram_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write   <= req_write;
                        r_signed  <= req_signed;
                        r_size    <= w_size_eff;
                        r_addr_lo <= w_addr_lo_eff;
                        r_wdata   <= req_wdata;
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            r_state    <= ST_RESP;
                        end else if (!req_write || (w_size_eff != SZ_WORD)) begin
                            ram_addr <= req_addr[ADDR_WIDTH+1:2];
                            r_state  <= ST_READ;
                        end else begin
                            ram_addr    <= req_addr[ADDR_WIDTH+1:2];
                            ram_wdata   <= req_wdata;
                            r_ram_write <= 1'b1;
                            r_state     <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (r_write) begin
                        ram_wdata   <= w_merged;
                        r_ram_write <= 1'b1;
                        r_state     <= ST_WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= w_load_data;
                        r_state    <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_master
// Description : Self-checking bench for mem_port_master with a word-RAM model
//               and a queue of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_master;
    import mem_port_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          req_signed = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    mem_port_master #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_write  (ram_write),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_wdata;

    // Reference load result: shift the lane down, then extend
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] s;
        s = w >> (8 * lo);
        if (sz == SZ_BYTE) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
        if (sz == SZ_HALF) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return w;
    endfunction

    // Drive one request and observe until the response pulse (cycle n = n-th negedge after accept)
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int wcyc, output int nwr,
                         output logic [AW-1:0] wa, output logic [31:0] wd);
        int guard;
        lat = -1; rd = '0; er = 1'b0; wcyc = -1; nwr = 0; wa = '0; wd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (ram_write) begin
                nwr++; wcyc = n; wa = ram_addr; wd = ram_wdata;
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0/0/0", resp_valid, resp_err, resp_rdata); end
        total++; if (ram_write !== 1'b0 || ram_addr !== '0 || ram_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_ram got w=%b a=%h d=%h exp 0/0/0", ram_write, ram_addr, ram_wdata); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word;
        int lat, wc, nw; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
        sb.push_back({32'h0, 1'b0});
        issue(1'b1, SZ_WORD, 1'b0, 32'h48, 32'hDEADBEEF, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (wc !== 1 || nw !== 1) begin bad++; $display("FAIL sw_write_cycle got cyc=%0d n=%0d exp cyc=1 n=1", wc, nw); end
        total++; if (wa !== 10'h012 || wd !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_ram got a=%h d=%h exp a=012 d=deadbeef", wa, wd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL sw_resp got d=%h e=%b exp d=%h e=%b", rd, er, e.rdata, e.err); end

        sb.push_back({32'hDEADBEEF, 1'b0});
        issue(1'b0, SZ_WORD, 1'b0, 32'h48, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || nw !== 0) begin bad++; $display("FAIL lw_timing got lat=%0d writes=%0d exp lat=2 writes=0", lat, nw); end
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lw_resp got d=%h e=%b exp d=%h e=%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_byte;
        int lat, wc, nw; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
        sb.push_back({32'h0, 1'b0});
        issue(1'b1, SZ_BYTE, 1'b0, 32'h49, 32'h1234565A, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (wc !== 2 || nw !== 1) begin bad++; $display("FAIL sb_write_cycle got cyc=%0d n=%0d exp cyc=2 n=1", wc, nw); end
        total++; if (wa !== 10'h012 || wd !== 32'hDEAD5AEF) begin bad++; $display("FAIL sb_merge got a=%h d=%h exp a=012 d=dead5aef", wa, wd); end
        total++; if (lat !== 3 || rd !== e.rdata || er !== e.err) begin
            bad++; $display("FAIL sb_resp got lat=%0d d=%h e=%b exp lat=3 d=%h e=%b", lat, rd, er, e.rdata, e.err); end

        sb.push_back({32'hFFFFFFDE, 1'b0});
        sb.push_back({32'h000000DE, 1'b0});
        issue(1'b0, SZ_BYTE, 1'b1, 32'h4B, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
            bad++; $display("FAIL lb_signed got lat=%0d d=%h e=%b exp lat=2 d=%h e=%b", lat, rd, er, e.rdata, e.err); end
        issue(1'b0, SZ_BYTE, 1'b0, 32'h4B, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lbu got d=%h e=%b exp d=%h e=%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_half;
        int lat, wc, nw; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
        issue(1'b1, SZ_WORD, 1'b0, 32'h48, 32'hDEADBEEF, lat, rd, er, wc, nw, wa, wd);
        sb.push_back({32'h0, 1'b0});
        issue(1'b1, SZ_HALF, 1'b0, 32'h4A, 32'hA5A58001, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 3 || wc !== 2 || rd !== e.rdata || er !== e.err) begin
            bad++; $display("FAIL sh_timing got lat=%0d wcyc=%0d d=%h exp lat=3 wcyc=2 d=%h", lat, wc, rd, e.rdata); end
        total++; if (mem[10'h012] !== 32'h8001BEEF) begin bad++; $display("FAIL sh_ram_word got=%h exp=8001beef", mem[10'h012]); end

        sb.push_back({32'hFFFF8001, 1'b0});
        sb.push_back({32'h00008001, 1'b0});
        sb.push_back({32'hFFFFBEEF, 1'b0});
        issue(1'b0, SZ_HALF, 1'b1, 32'h4A, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
            bad++; $display("FAIL lh_signed got lat=%0d d=%h exp lat=2 d=%h", lat, rd, e.rdata); end
        issue(1'b0, SZ_HALF, 1'b0, 32'h4A, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lhu got d=%h exp d=%h", rd, e.rdata); end
        issue(1'b0, SZ_HALF, 1'b1, 32'h48, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lh_low got d=%h exp d=%h", rd, e.rdata); end
    endtask

    task automatic test_misalign;
        int lat, wc, nw; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
`ifdef MEM_PORT_ALIGN_CHECK_EN
        sb.push_back({32'h0, 1'b1});
        sb.push_back({32'h0, 1'b1});
        sb.push_back({32'h0, 1'b1});
        issue(1'b0, SZ_WORD, 1'b0, 32'h49, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 1 || nw !== 0) begin bad++; $display("FAIL lw_misalign_timing got lat=%0d writes=%0d exp lat=1 writes=0", lat, nw); end
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lw_misalign_resp got d=%h e=%b exp d=%h e=%b", rd, er, e.rdata, e.err); end
        issue(1'b1, SZ_HALF, 1'b0, 32'h4B, 32'h1111, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 1 || nw !== 0 || er !== e.err || mem[10'h012] !== 32'h8001BEEF) begin
            bad++; $display("FAIL sh_misalign got lat=%0d writes=%0d e=%b word=%h exp lat=1 writes=0 e=1 word=8001beef", lat, nw, er, mem[10'h012]); end
        issue(1'b0, SZ_ILL, 1'b0, 32'h48, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 1 || er !== e.err) begin bad++; $display("FAIL size_illegal got lat=%0d e=%b exp lat=1 e=1", lat, er); end
`else
        sb.push_back({32'h8001BEEF, 1'b0});
        sb.push_back({32'h8001BEEF, 1'b0});
        sb.push_back({32'hFFFF8001, 1'b0});
        issue(1'b0, SZ_WORD, 1'b0, 32'h49, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || nw !== 0) begin bad++; $display("FAIL lw_misalign_timing got lat=%0d writes=%0d exp lat=2 writes=0", lat, nw); end
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lw_misalign_resp got d=%h e=%b exp d=%h e=%b", rd, er, e.rdata, e.err); end
        issue(1'b0, SZ_ILL, 1'b0, 32'h4A, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL size_illegal got lat=%0d d=%h e=%b exp lat=2 d=%h e=0", lat, rd, er, e.rdata); end
        issue(1'b0, SZ_HALF, 1'b1, 32'h4B, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL lh_misalign got d=%h exp d=%h", rd, e.rdata); end
`endif
    endtask

    task automatic test_wrap;
        int lat, wc, nw; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
        sb.push_back({32'h8001BEEF, 1'b0});
        issue(1'b0, SZ_WORD, 1'b0, 32'hF0001048, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL addr_wrap got lat=%0d d=%h exp lat=2 d=%h", lat, rd, e.rdata); end
    endtask

    task automatic test_back_to_back;
        int lat, wc, nw; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
        logic [31:0] words [4];
        logic [1:0] sz, lo; logic sg; int idx;
        words[0] = 32'h80FF7F01; words[1] = 32'h12345678;
        words[2] = 32'hFEDCBA98; words[3] = 32'h00807FFF;
        for (int i = 0; i < 4; i++)
            issue(1'b1, SZ_WORD, 1'b0, 32'h0C0 + 32'(i * 4), words[i], lat, rd, er, wc, nw, wa, wd);
        for (int i = 0; i < 10; i++) begin
            idx = int'($urandom_range(0, 3));
            sz  = 2'($urandom_range(0, 2));
            sg  = 1'($urandom_range(0, 1));
            lo  = (sz == SZ_BYTE) ? 2'($urandom_range(0, 3)) :
                  (sz == SZ_HALF) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            sb.push_back({ref_load(words[idx], lo, sz, sg), 1'b0});
            issue(1'b0, sz, sg, 32'h0C0 + 32'(idx * 4) + {30'h0, lo}, 32'h0, lat, rd, er, wc, nw, wa, wd);
            e = sb.pop_front();
            total++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
                bad++; $display("FAIL b2b_load[%0d] sz=%0d sg=%0d lo=%0d got lat=%0d d=%h exp lat=2 d=%h", i, sz, sg, lo, lat, rd, e.rdata); end
        end
    endtask

    task automatic test_busy;
        int guard, extra;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h0C4; req_wdata = 32'h0;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678) begin
            bad++; $display("FAIL busy_resp got v=%b d=%h exp v=1 d=12345678", resp_valid, resp_rdata); end
        req_valid = 1'b0;
        extra = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (resp_valid || ram_write) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL busy_reaccept got extra=%0d exp=0", extra); end
        total++; if (resp_rdata !== 32'h12345678) begin bad++; $display("FAIL resp_hold got=%h exp=12345678", resp_rdata); end
    endtask

    task automatic test_reset_mid;
        int lat, wc, nw, guard; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa; exp_t e;
        issue(1'b1, SZ_WORD, 1'b0, 32'h80, 32'h11223344, lat, rd, er, wc, nw, wa, wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h80; req_wdata = 32'hCAFEF00D;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL reset_mid_write got=%b exp=0", ram_write); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid_idle got rdy=%b v=%b exp rdy=1 v=0", req_ready, resp_valid); end
        total++; if (mem[10'h020] !== 32'h11223344) begin bad++; $display("FAIL reset_mid_ram got=%h exp=11223344", mem[10'h020]); end
        sb.push_back({32'h11223344, 1'b0});
        issue(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, lat, rd, er, wc, nw, wa, wd);
        e = sb.pop_front();
        total++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
            bad++; $display("FAIL reset_mid_reload got lat=%0d d=%h exp lat=2 d=%h", lat, rd, e.rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
